// File: rtl/seg_scan_ctrl_pkg.sv
// rtl/seg_scan_ctrl_pkg.sv - shared constants and types for the seven-segment scan controller
package seg_pkg;

  localparam int NDIG = 8;

  // Active-low abcdefg: bit 6 is segment a, bit 0 is segment g.
  localparam logic [6:0] SEG_OFF  = 7'h7F;
  localparam logic [6:0] SEG_DASH = 7'b1111110;

  localparam logic [6:0] HEX_SEG [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  typedef enum logic {
    BLANK = 1'b0,
    ON    = 1'b1
  } phase_e;

endpackage

// File: rtl/seg_scan_ctrl_if.sv
// rtl/seg_scan_ctrl_if.sv - valid/ready display-value handshake between producer and scanner
interface seg_scan_ctrl_if;

  logic [31:0] data_in;
  logic        data_valid;
  logic        data_ready;

  modport master (
    output data_in,
    output data_valid,
    input  data_ready
  );

  modport slave (
    input  data_in,
    input  data_valid,
    output data_ready
  );

endinterface

// File: rtl/seg_scan_ctrl_hex_decode.sv
// rtl/seg_scan_ctrl_hex_decode.sv - nibble to active-low segment decode with busy dash override
module seg_hex_decode
  import seg_pkg::*;
(
  input  logic [3:0] nib_i,
  input  logic       busy_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = HEX_SEG[nib_i];
    if (busy_i) begin
      seg_o = SEG_DASH;
    end
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// rtl/seg_scan_ctrl.sv - single-clock 8-digit scan scheduler with frame-aligned value updates
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int SCAN_DIV  = 20000,
  parameter int BLANK_CYC = 16
) (
  input  logic            clk,
  input  logic            rst,
  seg_scan_ctrl_if.slave  data_if,
  input  logic            busy,
  output logic            frame_tick,
  output logic [NDIG-1:0] led_en,
  output logic            led_ca,
  output logic            led_cb,
  output logic            led_cc,
  output logic            led_cd,
  output logic            led_ce,
  output logic            led_cf,
  output logic            led_cg,
  output logic            led_dp
);

  localparam int CW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam int DW = $clog2(NDIG);
  localparam logic [CW-1:0] CNT_MAX = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] BLANK_C = CW'(BLANK_CYC);
  localparam logic [DW-1:0] DIG_MAX = DW'(NDIG - 1);

  logic [CW-1:0]   cnt_q, cnt_d;
  logic [DW-1:0]   dig_q, dig_d;
  logic [31:0]     disp_q, disp_d;
  logic [31:0]     pend_reg_q, pend_reg_d;
  logic            pend_q, pend_d;
  logic            busy_q, busy_d;
  phase_e          phase_q, phase_d;
  logic [NDIG-1:0] led_en_q, led_en_d;
  logic [6:0]      seg_q, seg_d;
  logic            frame_tick_q, frame_tick_d;

  logic            slot_end;
  logic            frame_end;
  logic            accept;
  logic [3:0]      nib;
  logic [6:0]      seg_dec;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q        <= '0;
      dig_q        <= '0;
      disp_q       <= '0;
      pend_reg_q   <= '0;
      pend_q       <= 1'b0;
      busy_q       <= 1'b0;
      phase_q      <= BLANK;
      led_en_q     <= '1;
      seg_q        <= SEG_OFF;
      frame_tick_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      dig_q        <= dig_d;
      disp_q       <= disp_d;
      pend_reg_q   <= pend_reg_d;
      pend_q       <= pend_d;
      busy_q       <= busy_d;
      phase_q      <= phase_d;
      led_en_q     <= led_en_d;
      seg_q        <= seg_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  always_comb begin
    slot_end   = (cnt_q == CNT_MAX);
    frame_end  = slot_end && (dig_q == DIG_MAX);
    accept     = data_if.data_valid && !pend_q;

    cnt_d      = slot_end ? '0 : cnt_q + 1'b1;
    dig_d      = slot_end ? dig_q + 1'b1 : dig_q;
    busy_d     = slot_end ? busy : busy_q;

    disp_d     = disp_q;
    pend_reg_d = pend_reg_q;
    pend_d     = pend_q;

    // A value accepted on the frame-end cycle bypasses the pending buffer.
    if (frame_end) begin
      if (accept) begin
        disp_d = data_if.data_in;
      end else if (pend_q) begin
        disp_d = pend_reg_q;
        pend_d = 1'b0;
      end
    end else if (accept) begin
      pend_reg_d = data_if.data_in;
      pend_d     = 1'b1;
    end
  end

  always_comb begin
    phase_d = phase_q;
    unique case (phase_q)
      BLANK: if (cnt_d >= BLANK_C) phase_d = ON;
      ON:    if (slot_end && (BLANK_CYC > 0)) phase_d = BLANK;
      default: phase_d = BLANK;
    endcase
  end

  // Outputs are computed from next-state values so the flops line up with cnt/dig.
  assign nib = disp_d[{dig_d, 2'b00} +: 4];

  seg_hex_decode u_hex (
    .nib_i  (nib),
    .busy_i (busy_d),
    .seg_o  (seg_dec)
  );

  always_comb begin
    led_en_d     = '1;
    seg_d        = SEG_OFF;
    frame_tick_d = (cnt_d == CNT_MAX) && (dig_d == DIG_MAX);
    if (phase_d == ON) begin
      led_en_d = ~(NDIG'(1) << dig_d);
      seg_d    = seg_dec;
    end
  end

  assign data_if.data_ready = !pend_q;
  assign frame_tick = frame_tick_q;
  assign led_en     = led_en_q;
  assign led_ca     = seg_q[6];
  assign led_cb     = seg_q[5];
  assign led_cc     = seg_q[4];
  assign led_cd     = seg_q[3];
  assign led_ce     = seg_q[2];
  assign led_cf     = seg_q[1];
  assign led_cg     = seg_q[0];
  assign led_dp     = 1'b1;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb/tb_seg_scan_ctrl.sv - directed self-checking bench for seg_scan_ctrl
module tb_seg_scan_ctrl;

  logic       clk;
  logic       rst;
  logic       busy;
  logic       frame_tick;
  logic [7:0] led_en;
  logic       led_ca, led_cb, led_cc, led_cd, led_ce, led_cf, led_cg, led_dp;

  seg_scan_ctrl_if sif ();

  seg_scan_ctrl #(.SCAN_DIV(8), .BLANK_CYC(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .data_if    (sif.slave),
    .busy       (busy),
    .frame_tick (frame_tick),
    .led_en     (led_en),
    .led_ca     (led_ca),
    .led_cb     (led_cb),
    .led_cc     (led_cc),
    .led_cd     (led_cd),
    .led_ce     (led_ce),
    .led_cf     (led_cf),
    .led_cg     (led_cg),
    .led_dp     (led_dp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [6:0] hex_tbl [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  int          checks = 0;
  int          errors = 0;
  int          t;
  logic [31:0] m_disp;
  logic [31:0] m_pval;
  logic        m_pend;
  logic        m_ready;
  logic        m_busy;

  function automatic logic [6:0] seg_now();
    return {led_ca, led_cb, led_cc, led_cd, led_ce, led_cf, led_cg};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s t=%0d: observed %0h expected %0h", tag, t, obs, exp);
    end
  endtask

  task automatic check_outputs();
    int         c;
    int         d;
    logic [7:0] en;
    logic [6:0] sg;
    logic [3:0] nib;
    c = t % 8;
    d = (t / 8) % 8;
    if (c < 2) begin
      en = 8'hFF;
      sg = 7'h7F;
    end else begin
      en  = ~(8'b1 << d);
      nib = m_disp[d*4 +: 4];
      sg  = m_busy ? 7'b1111110 : hex_tbl[nib];
    end
    check("led_en", 32'(led_en), 32'(en));
    check("seg", 32'(seg_now()), 32'(sg));
    check("frame_tick", 32'(frame_tick), 32'((t % 64) == 63));
    check("data_ready", 32'(sif.data_ready), 32'(m_ready));
    check("led_dp", 32'(led_dp), 32'd1);
  endtask

  task automatic model_reset();
    t       = 0;
    m_disp  = '0;
    m_pval  = '0;
    m_pend  = 1'b0;
    m_ready = 1'b1;
    m_busy  = 1'b0;
  endtask

  task automatic step();
    logic acc;
    logic fe;
    logic b_at;
    acc  = sif.data_valid && m_ready;
    fe   = (t % 64) == 63;
    b_at = busy;
    @(posedge clk);
    #1;
    t++;
    if (t % 8 == 0) m_busy = b_at;
    if (fe) begin
      if (acc) begin
        m_disp = sif.data_in;
      end else if (m_pend) begin
        m_disp = m_pval;
        m_pend = 1'b0;
      end
    end else if (acc) begin
      m_pend = 1'b1;
      m_pval = sif.data_in;
    end
    m_ready = !m_pend;
    check_outputs();
  endtask

  task automatic run_to(input int tt);
    while (t < tt) step();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_en"}, 32'(led_en), 32'hFF);
    check({tag, "_seg"}, 32'(seg_now()), 32'h7F);
    check({tag, "_dp"}, 32'(led_dp), 32'd1);
    check({tag, "_ready"}, 32'(sif.data_ready), 32'd1);
    check({tag, "_tick"}, 32'(frame_tick), 32'd0);
  endtask

  initial begin
    logic acc_now;
    rst            = 1'b1;
    busy           = 1'b0;
    sif.data_in    = '0;
    sif.data_valid = 1'b0;
    model_reset();
    #1;
    check_reset_outputs("reset");
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    check_outputs();

    // Idle frame: zeros on every digit, 0 -> 7 order
    run_to(2);
    check("t1_dig0_on_en", 32'(led_en), 32'hFE);
    check("t1_dig0_zero", 32'(seg_now()), 32'b0000001);
    run_to(63);
    check("t1_tick", 32'(frame_tick), 32'd1);
    run_to(74);

    // Mid-frame accept
    sif.data_in    = 32'h1234ABCD;
    sif.data_valid = 1'b1;
    step();
    sif.data_valid = 1'b0;
    check("t2_ready_low", 32'(sif.data_ready), 32'd0);
    run_to(127);
    check("t2_ready_held", 32'(sif.data_ready), 32'd0);
    step();
    check("t2_ready_back", 32'(sif.data_ready), 32'd1);
    run_to(130);
    check("t2_dig0_d", 32'(seg_now()), 32'b1000010);
    run_to(186);
    check("t2_dig7_1", 32'(seg_now()), 32'b1001111);
    run_to(212);

    // Back-to-back valids
    sif.data_in    = 32'hA5A55A5A;
    sif.data_valid = 1'b1;
    step();
    sif.data_in = 32'hFFFF0000;
    acc_now     = 1'b0;
    while (!acc_now) begin
      acc_now = m_ready;
      step();
    end
    sif.data_valid = 1'b0;
    check("t3_second_acc_time", 32'(t), 32'd257);
    check("t3_ready_low", 32'(sif.data_ready), 32'd0);
    run_to(258);
    check("t3_first_dig0", 32'(seg_now()), 32'b0001000);
    run_to(266);
    check("t3_first_dig1", 32'(seg_now()), 32'b0100100);
    run_to(314);
    check("t3_first_dig7", 32'(seg_now()), 32'b0001000);
    run_to(322);
    check("t3_second_dig0", 32'(seg_now()), 32'b0000001);
    run_to(378);
    check("t3_second_dig7", 32'(seg_now()), 32'b0111000);

    // Accept on the frame_tick cycle
    run_to(383);
    check("t4_on_tick", 32'(frame_tick), 32'd1);
    sif.data_in    = 32'h0F1E2D3C;
    sif.data_valid = 1'b1;
    step();
    sif.data_valid = 1'b0;
    check("t4_ready_kept", 32'(sif.data_ready), 32'd1);
    run_to(386);
    check("t4_dig0_C", 32'(seg_now()), 32'b0110001);

    // busy raised and dropped mid-slot
    run_to(388);
    busy = 1'b1;
    run_to(390);
    check("t5_slot_unchanged", 32'(seg_now()), 32'b0110001);
    run_to(394);
    check("t5_dash", 32'(seg_now()), 32'b1111110);
    run_to(404);
    busy = 1'b0;
    run_to(406);
    check("t5_dash_held", 32'(seg_now()), 32'b1111110);
    run_to(410);
    check("t5_hex_back", 32'(seg_now()), 32'b0010010);

    // Async reset mid-slot with a value pending
    run_to(420);
    sif.data_in    = 32'h77777777;
    sif.data_valid = 1'b1;
    step();
    sif.data_valid = 1'b0;
    check("t6_pending", 32'(sif.data_ready), 32'd0);
    run_to(428);
    check("t6_pre_on", 32'(led_en), 32'hDF);
    #2;
    rst = 1'b1;
    #1;
    check_reset_outputs("t6_async");
    @(posedge clk);
    #1;
    check_reset_outputs("t6_held");
    rst = 1'b0;
    model_reset();
    check_outputs();
    run_to(66);
    check("t6_dig0_zero", 32'(seg_now()), 32'b0000001);
    run_to(122);
    check("t6_dig7_zero", 32'(seg_now()), 32'b0000001);
    run_to(130);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
